incdec_latch: RTL

- 16-bit increment/decrement address latch for the 8085 core.
- Captures a register-pair value (PC, SP, HL, BC or DE) and drives the original value onto the address path.
- Computes value+1, value-1 or pass-through, then presents the result with a one-cycle write strobe.
- Directly upstream of a `register` instance: data_out feeds its data_in and wr_enb feeds its enb.

---
 rtl/incdec_latch_if.sv | 27 ++
 rtl/incdec_latch.sv | 130 +++++++++++++
 2 files changed

// File: rtl/incdec_latch_if.sv
// Handshake and data bundle between a requester
// and the inc/dec address latch.
interface incdec_latch_if #(
  parameter int DATASIZE = 16
);
  logic                req;
  logic [1:0]          mode;
  logic [DATASIZE-1:0] data_in;
  logic [DATASIZE-1:0] addr_out;
  logic [DATASIZE-1:0] data_out;
  logic                wr_enb;
  logic                busy;
  logic                done;
  logic                wrap;

  modport master (
    output req, mode, data_in,
    input  addr_out, data_out,
    input  wr_enb, busy, done, wrap
  );

  modport slave (
    input  req, mode, data_in,
    output addr_out, data_out,
    output wr_enb, busy, done, wrap
  );
endinterface

// File: rtl/incdec_latch.sv
// 16-bit increment/decrement address latch.
// Captures, computes, then strobes one write.
module incdec_latch #(
  parameter int DATASIZE = 16
) (
  input logic          clk,
  input logic          rst,
  incdec_latch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    WRITE
  } state_t;

  localparam logic [DATASIZE:0] ONE =
    {{DATASIZE{1'b0}}, 1'b1};

  state_t              state_q, state_nxt;
  logic [DATASIZE-1:0] operand_q, operand_nxt;
  logic [1:0]          op_mode_q, op_mode_nxt;
  logic [DATASIZE-1:0] addr_q, addr_nxt;
  logic [DATASIZE-1:0] data_q, data_nxt;
  logic                wr_q, wr_nxt;
  logic                busy_q, busy_nxt;
  logic                done_q, done_nxt;
  logic                wrap_q, wrap_nxt;

  logic [DATASIZE:0]   sum_inc;
  logic [DATASIZE:0]   sum_dec;
  logic                is_inc;
  logic                is_dec;

  assign is_inc  = (op_mode_q == 2'b01);
  assign is_dec  = (op_mode_q == 2'b10);
  // The extra top bit is the carry/borrow out.
  assign sum_inc = {1'b0, operand_q} + ONE;
  assign sum_dec = {1'b0, operand_q} - ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      operand_q <= '0;
      op_mode_q <= 2'b00;
      addr_q    <= '0;
      data_q    <= '0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      operand_q <= operand_nxt;
      op_mode_q <= op_mode_nxt;
      addr_q    <= addr_nxt;
      data_q    <= data_nxt;
      wr_q      <= wr_nxt;
      busy_q    <= busy_nxt;
      done_q    <= done_nxt;
      wrap_q    <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt   = state_q;
    operand_nxt = operand_q;
    op_mode_nxt = op_mode_q;
    addr_nxt    = addr_q;
    data_nxt    = data_q;
    wr_nxt      = 1'b0;
    busy_nxt    = busy_q;
    done_nxt    = 1'b0;
    wrap_nxt    = wrap_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req) begin
          operand_nxt = bus.data_in;
          addr_nxt    = bus.data_in;
          op_mode_nxt = bus.mode;
          wrap_nxt    = 1'b0;
          busy_nxt    = 1'b1;
          state_nxt   = CALC;
        end
      end
      CALC: begin
        unique case (1'b1)
          is_inc: begin
            data_nxt = sum_inc[DATASIZE-1:0];
            wrap_nxt = sum_inc[DATASIZE];
          end
          is_dec: begin
            data_nxt = sum_dec[DATASIZE-1:0];
            wrap_nxt = sum_dec[DATASIZE];
          end
          default: begin
            data_nxt = operand_q;
            wrap_nxt = 1'b0;
          end
        endcase
        wr_nxt    = 1'b1;
        done_nxt  = 1'b1;
        state_nxt = WRITE;
      end
      WRITE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.addr_out = addr_q;
  assign bus.data_out = data_q;
  assign bus.wr_enb   = wr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.wrap     = wrap_q;

endmodule
